// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for the knight's-tour command sequencer:
// FSM states, command opcodes, heading bytes and response bytes.
package tour_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLDV,
        HORZ,
        HOLDH
    } tour_state_t;

    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_MOVE = 5'd23;

    localparam logic [3:0] MOVE         = 4'h2;
    localparam logic [3:0] MOVE_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_NORTH = 8'h00;
    localparam logic [7:0] HEAD_SOUTH = 8'h7F;
    localparam logic [7:0] HEAD_WEST  = 8'h3F;
    localparam logic [7:0] HEAD_EAST  = 8'hBF;

    localparam logic [7:0] RESP_IDLE = 8'hA5;
    localparam logic [7:0] RESP_TOUR = 8'h5A;

    // Unsigned square count of a signed 3-bit displacement, as the 4-bit command field.
    function automatic logic [3:0] magnitude(input logic signed [2:0] d);
        logic [2:0] mag;
        mag = d[2] ? (~d + 3'd1) : d;
        return {1'b0, mag};
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Handshake bundle between the tour sequencer, the tour solver and the
// UART / command-processor side.
interface tour_cmd_if;
    import tour_cmd_pkg::*;

    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic [7:0]       resp;

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, cmd, cmd_rdy, resp
    );

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, cmd, cmd_rdy, resp
    );

endinterface

// File: rtl/tour_cmd_move_decode.sv
// Combinational decode of a one-hot knight move into signed (dx, dy).
// Multi-bit moves take the lowest set bit; an all-zero move means no motion.
module move_decode (
    input  logic [7:0]        move,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy
);

    always_comb begin
        // NOTE: defaults first so every path assigns dx/dy and no latch is inferred.
        dx = 3'sd0;
        dy = 3'sd0;
        casez (move)
            8'b???????1: begin dx = -3'sd1; dy =  3'sd2; end
            8'b??????10: begin dx =  3'sd1; dy =  3'sd2; end
            8'b?????100: begin dx = -3'sd2; dy =  3'sd1; end
            8'b????1000: begin dx = -3'sd2; dy = -3'sd1; end
            8'b???10000: begin dx = -3'sd1; dy = -3'sd2; end
            8'b??100000: begin dx =  3'sd1; dy = -3'sd2; end
            8'b?1000000: begin dx =  3'sd2; dy = -3'sd1; end
            8'b10000000: begin dx =  3'sd2; dy =  3'sd1; end
            default:     begin dx =  3'sd0; dy =  3'sd0; end
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as vertical/horizontal move commands,
// muxed with the UART command path while idle.
module tour_cmd
    import tour_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    tour_cmd_if.slave  bus
);

    tour_state_t       state, state_nxt;
    logic [IDX_W-1:0]  mv_indx;
    logic signed [2:0] dx, dy;
    logic              last_move;
    logic [15:0]       vert_cmd, horz_cmd;

    move_decode u_move_decode (
        .move (bus.move),
        .dx   (dx),
        .dy   (dy)
    );

    assign last_move   = (mv_indx == LAST_MOVE);
    assign bus.mv_indx = mv_indx;

    assign vert_cmd = {MOVE,         dy[2] ? HEAD_SOUTH : HEAD_NORTH, magnitude(dy)};
    assign horz_cmd = {MOVE_FANFARE, dx[2] ? HEAD_WEST  : HEAD_EAST,  magnitude(dx)};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mv_indx <= '0;
        else if (state == IDLE && bus.start_tour)
            mv_indx <= '0;
        else if (state == HOLDH && bus.send_resp && !last_move)
            mv_indx <= mv_indx + 5'd1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start_tour)  state_nxt = VERT;
            VERT:  if (bus.clr_cmd_rdy) state_nxt = HOLDV;
            HOLDV: if (bus.send_resp)   state_nxt = HORZ;
            HORZ:  if (bus.clr_cmd_rdy) state_nxt = HOLDH;
            HOLDH: if (bus.send_resp)   state_nxt = last_move ? IDLE : VERT;
            default:                    state_nxt = IDLE;
        endcase
    end

    // The final send_resp already reports idle so the command processor sees
    // the tour end in the same cycle it finishes the last leg.
    always_comb begin
        bus.cmd     = bus.cmd_UART;
        bus.cmd_rdy = bus.cmd_rdy_UART;
        bus.resp    = RESP_IDLE;
        unique case (state)
            IDLE: ;
            VERT: begin
                bus.cmd     = vert_cmd;
                bus.cmd_rdy = 1'b1;
                bus.resp    = RESP_TOUR;
            end
            HOLDV: begin
                bus.cmd     = vert_cmd;
                bus.cmd_rdy = 1'b0;
                bus.resp    = RESP_TOUR;
            end
            HORZ: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b1;
                bus.resp    = RESP_TOUR;
            end
            HOLDH: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b0;
                bus.resp    = (bus.send_resp && last_move) ? RESP_IDLE : RESP_TOUR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: fixed move vectors, a randomized full
// tour against a table-based move model, reset abort and ignored-input cases.
module tb_tour_cmd;

    logic clk = 1'b0;
    logic rst;

    tour_cmd_if bus ();

    tour_cmd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Solver stand-in: the move presented follows whatever index the DUT asks for.
    logic [7:0] moves [32];
    assign bus.move = moves[bus.mv_indx];

    int dx_tab [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    int dy_tab [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    typedef struct {
        logic [7:0]  move;
        logic [15:0] vert;
        logic [15:0] horz;
    } vec_t;

    vec_t vecs [12];

    int rdy_pulses = 0;
    logic rdy_prev = 1'b0;

    always @(negedge clk) begin
        rdy_prev <= bus.cmd_rdy;
        if (bus.cmd_rdy && !rdy_prev) rdy_pulses <= rdy_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void decode(input logic [7:0] m, output int dx, output int dy);
        dx = 0;
        dy = 0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                dx = dx_tab[i];
                dy = dy_tab[i];
            end
        end
    endfunction

    function automatic logic [15:0] exp_vert(input logic [7:0] m);
        int dx, dy;
        decode(m, dx, dy);
        return {4'h2, (dy < 0) ? 8'h7F : 8'h00, 4'((dy < 0) ? -dy : dy)};
    endfunction

    function automatic logic [15:0] exp_horz(input logic [7:0] m);
        int dx, dy;
        decode(m, dx, dy);
        return {4'h3, (dx < 0) ? 8'h3F : 8'hBF, 4'((dx < 0) ? -dx : dx)};
    endfunction

    task automatic clear_pulses();
        bus.start_tour  = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_pulses();
        #1;
    endtask

    task automatic do_reset();
        clear_pulses();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic start();
        bus.start_tour = 1'b1;
        cyc();
        check("start_rdy", 32'(bus.cmd_rdy), 1);
        check("start_idx", 32'(bus.mv_indx), 0);
    endtask

    // Random irrelevant activity in a tour state; nothing observable may change.
    task automatic noise(input int k, input logic [15:0] exp_cmd, input bit exp_rdy,
                         input bit allow_clr, input bit allow_resp);
        repeat ($urandom_range(0, 2)) begin
            bus.start_tour = 1'($urandom_range(0, 1));
            if (allow_clr)  bus.clr_cmd_rdy = 1'($urandom_range(0, 1));
            if (allow_resp) bus.send_resp   = 1'($urandom_range(0, 1));
            cyc();
            check("noise_rdy", 32'(bus.cmd_rdy), 32'(exp_rdy));
            check("noise_idx", 32'(bus.mv_indx), k);
            check("noise_cmd", 32'(bus.cmd), 32'(exp_cmd));
        end
    endtask

    // Entered in VERT for move k; leaves in VERT of k+1 (or IDLE) if finish, else in HOLDH.
    task automatic step_move(input int k, input bit noisy, input bit finish);
        logic [15:0] v, h;
        v = exp_vert(moves[k]);
        h = exp_horz(moves[k]);
        check("vert_cmd",  32'(bus.cmd), 32'(v));
        check("vert_rdy",  32'(bus.cmd_rdy), 1);
        check("vert_idx",  32'(bus.mv_indx), k);
        check("vert_resp", 32'(bus.resp), 32'h5A);
        if (noisy) noise(k, v, 1'b1, 1'b0, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        cyc();
        check("holdv_rdy", 32'(bus.cmd_rdy), 0);
        check("holdv_cmd", 32'(bus.cmd), 32'(v));
        if (noisy) noise(k, v, 1'b0, 1'b1, 1'b0);
        bus.send_resp = 1'b1;
        cyc();
        check("horz_rdy",  32'(bus.cmd_rdy), 1);
        check("horz_cmd",  32'(bus.cmd), 32'(h));
        check("horz_idx",  32'(bus.mv_indx), k);
        check("horz_resp", 32'(bus.resp), 32'h5A);
        if (noisy) noise(k, h, 1'b1, 1'b0, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        cyc();
        check("holdh_rdy", 32'(bus.cmd_rdy), 0);
        check("holdh_cmd", 32'(bus.cmd), 32'(h));
        if (noisy) noise(k, h, 1'b0, 1'b1, 1'b0);
        if (finish) begin
            if (k == 23) bus.cmd_rdy_UART = 1'b0;
            bus.send_resp = 1'b1;
            #1;
            check("holdh_resp", 32'(bus.resp), (k == 23) ? 32'hA5 : 32'h5A);
            cyc();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        vecs[0]  = '{8'h01, 16'h2002, 16'h33F1};
        vecs[1]  = '{8'h02, 16'h2002, 16'h3BF1};
        vecs[2]  = '{8'h04, 16'h2001, 16'h33F2};
        vecs[3]  = '{8'h08, 16'h27F1, 16'h33F2};
        vecs[4]  = '{8'h10, 16'h27F2, 16'h33F1};
        vecs[5]  = '{8'h20, 16'h27F2, 16'h3BF1};
        vecs[6]  = '{8'h40, 16'h27F1, 16'h3BF2};
        vecs[7]  = '{8'h80, 16'h2001, 16'h3BF2};
        vecs[8]  = '{8'h00, 16'h2000, 16'h3BF0};
        vecs[9]  = '{8'h06, 16'h2002, 16'h3BF1};
        vecs[10] = '{8'hC0, 16'h27F1, 16'h3BF2};
        vecs[11] = '{8'hFF, 16'h2002, 16'h33F1};

        for (int i = 0; i < 32; i++) moves[i] = 8'h00;
        bus.cmd_UART     = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        rst              = 1'b0;
        clear_pulses();

        // Reset state and UART pass-through in IDLE.
        do_reset();
        check("rst_rdy",  32'(bus.cmd_rdy), 0);
        check("rst_idx",  32'(bus.mv_indx), 0);
        check("rst_resp", 32'(bus.resp), 32'hA5);
        check("rst_cmd",  32'(bus.cmd), 0);
        bus.cmd_UART     = 16'h2004;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        check("idle_cmd",  32'(bus.cmd), 32'h2004);
        check("idle_rdy",  32'(bus.cmd_rdy), 1);
        check("idle_resp", 32'(bus.resp), 32'hA5);
        bus.send_resp = 1'b1;
        bus.clr_cmd_rdy = 1'b1;
        cyc();
        check("idle_hold_rdy", 32'(bus.cmd_rdy), 1);
        check("idle_hold_cmd", 32'(bus.cmd), 32'h2004);
        bus.cmd_rdy_UART = 1'b0;
        bus.cmd_UART     = 16'h0000;
        #1;

        // Fixed move vectors, each tour aborted by the next reset.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            moves[0] = vecs[i].move;
            start();
            check($sformatf("tbl%0d_vert", i), 32'(bus.cmd), 32'(vecs[i].vert));
            bus.clr_cmd_rdy = 1'b1;
            cyc();
            bus.send_resp = 1'b1;
            cyc();
            check($sformatf("tbl%0d_horz", i), 32'(bus.cmd), 32'(vecs[i].horz));
        end

        // Full randomized tour with ignored inputs sprinkled in.
        for (int k = 0; k < 24; k++)
            moves[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'(1 << $urandom_range(0, 7));
        do_reset();
        @(negedge clk);
        base = rdy_pulses;
        #3;
        start();
        bus.cmd_UART     = 16'hFFFF;
        bus.cmd_rdy_UART = 1'b1;
        for (int k = 0; k < 24; k++) step_move(k, 1'b1, 1'b1);
        check("end_resp", 32'(bus.resp), 32'hA5);
        check("end_rdy",  32'(bus.cmd_rdy), 0);
        check("end_cmd",  32'(bus.cmd), 32'hFFFF);
        check("end_idx",  32'(bus.mv_indx), 23);
        @(negedge clk);
        check("tour_pulses", 32'(rdy_pulses - base), 48);
        #3;
        start();
        check("restart_cmd", 32'(bus.cmd), 32'(exp_vert(moves[0])));

        // Reset in HOLDH at move 10 aborts; next start resumes at 0.
        do_reset();
        bus.cmd_UART = 16'h1234;
        start();
        for (int k = 0; k < 10; k++) step_move(k, 1'b0, 1'b1);
        step_move(10, 1'b0, 1'b0);
        check("pre_abort_idx", 32'(bus.mv_indx), 10);
        #3;
        rst = 1'b1;
        #1;
        check("abort_idx",  32'(bus.mv_indx), 0);
        check("abort_rdy",  32'(bus.cmd_rdy), 0);
        check("abort_cmd",  32'(bus.cmd), 32'h1234);
        check("abort_resp", 32'(bus.resp), 32'hA5);
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.send_resp = 1'b1;
            bus.clr_cmd_rdy = 1'b1;
            cyc();
            check("post_abort_rdy",  32'(bus.cmd_rdy), 0);
            check("post_abort_idx",  32'(bus.mv_indx), 0);
            check("post_abort_resp", 32'(bus.resp), 32'hA5);
        end
        start();
        step_move(0, 1'b0, 1'b1);
        check("resume_idx", 32'(bus.mv_indx), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
